// File: rtl/cfg_uart.sv
// cfg_uart: UART endpoint for the PID control FSM's command interface.
//   Receives 3-byte configuration frames on RX and presents them on cfg_data
//   with a frm_rdy/clr_rdy handshake. On strt_tx it sends a 16-bit response
//   on TX as two bytes, MSB byte first.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   RX              serial in (idle high, asynchronous to clk)
//   TX              serial out (idle high)
//   cfg_data[23:0]  last complete frame, byte0 in [23:16]
//   frm_rdy         an unconsumed frame is held in cfg_data
//   clr_rdy         one-cycle pulse that consumes the frame
//   strt_tx         one-cycle pulse that latches tx_data and starts sending
//   tx_data[15:0]   response word
//   tx_busy         transmitter active
//   frm_ovr         one-cycle pulse: frame completed while frm_rdy was high
module cfg_uart #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned FRAME_TO = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cfg_data,
  output logic        frm_rdy,
  input  logic        clr_rdy,
  input  logic        strt_tx,
  input  logic [15:0] tx_data,
  output logic        tx_busy,
  output logic        frm_ovr
);

  localparam int unsigned CW     = $clog2(BAUD_DIV);
  localparam int unsigned TO_CYC = FRAME_TO * BAUD_DIV;
  localparam int unsigned TW     = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t     rx_state, rx_next;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rearm_wait;
  logic          rx_tick, byte_ok, frame_err;

  assign rx_tick = (rx_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next   = rx_state;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rearm_wait && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_next   = RX_IDLE;
          byte_ok   = rx_sync;
          frame_err = !rx_sync;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rearm_wait <= 1'b0;
    end else begin
      // IDLE keeps the half-bit preload so START samples mid start bit
      if (rx_state == RX_IDLE) rx_cnt <= HALF_LAST;
      else if (rx_tick)        rx_cnt <= BIT_LAST;
      else                     rx_cnt <= rx_cnt - 1'b1;

      if (rx_state != RX_DATA) rx_bit <= '0;
      else if (rx_tick)        rx_bit <= rx_bit + 3'd1;

      if (rx_state == RX_DATA && rx_tick) rx_sh <= {rx_sync, rx_sh[7:1]};

      // after a framing error the line must return high before a new start
      if (frame_err)                               rearm_wait <= 1'b1;
      else if (rx_state == RX_IDLE && rx_sync)     rearm_wait <= 1'b0;
    end
  end

  // --------------------------------------------------------- frame assembly
  logic [1:0]    byte_cnt;
  logic [7:0]    b0, b1, b2;
  logic          frm_done;
  logic [TW-1:0] to_cnt;
  logic          to_arm, timeout;

  assign to_arm  = (byte_cnt != '0) && (rx_state == RX_IDLE);
  assign timeout = to_arm && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      b0       <= '0;
      b1       <= '0;
      b2       <= '0;
      frm_done <= 1'b0;
      to_cnt   <= '0;
    end else begin
      frm_done <= byte_ok && (byte_cnt == 2'd2);

      if (!to_arm || timeout) to_cnt <= '0;
      else                    to_cnt <= to_cnt + 1'b1;

      if (frame_err || timeout) begin
        byte_cnt <= '0;
      end else if (byte_ok) begin
        case (byte_cnt)
          2'd0:    begin b0 <= rx_sh; byte_cnt <= 2'd1; end
          2'd1:    begin b1 <= rx_sh; byte_cnt <= 2'd2; end
          default: begin b2 <= rx_sh; byte_cnt <= 2'd0; end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_data <= '0;
      frm_rdy  <= 1'b0;
      frm_ovr  <= 1'b0;
    end else begin
      frm_ovr <= 1'b0;
      if (frm_done) begin
        // a new frame outranks a coincident clr_rdy
        cfg_data <= {b0, b1, b2};
        frm_rdy  <= 1'b1;
        frm_ovr  <= frm_rdy && !clr_rdy;
      end else if (clr_rdy) begin
        frm_rdy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh, tx_lo;
  logic          tx_second;
  logic          tx_tick, tx_out;

  assign tx_tick = (tx_cnt == '0);
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_out  = TX;
    case (tx_state)
      TX_IDLE: begin
        if (strt_tx) begin
          tx_next = TX_START;
          tx_out  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_next = TX_DATA;
          tx_out  = tx_sh[0];
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            tx_next = TX_STOP;
            tx_out  = 1'b1;
          end else begin
            tx_out  = tx_sh[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_next = tx_second ? TX_IDLE : TX_START;
          tx_out  = tx_second;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX        <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_lo     <= '0;
      tx_second <= 1'b0;
    end else begin
      TX <= tx_out;

      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= BIT_LAST;
      else                                tx_cnt <= tx_cnt - 1'b1;

      if (tx_state != TX_DATA) tx_bit <= '0;
      else if (tx_tick)        tx_bit <= tx_bit + 3'd1;

      case (tx_state)
        TX_IDLE: begin
          if (strt_tx) begin
            tx_sh     <= tx_data[15:8];
            tx_lo     <= tx_data[7:0];
            tx_second <= 1'b0;
          end
        end
        TX_DATA: if (tx_tick) tx_sh <= {1'b0, tx_sh[7:1]};
        TX_STOP: begin
          if (tx_tick && !tx_second) begin
            tx_sh     <= tx_lo;
            tx_second <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_uart.sv
// Testbench for cfg_uart with BAUD_DIV=8, FRAME_TO=20.
module tb_cfg_uart;

  localparam int unsigned BD = 8;
  // clr_rdy drive offset (cycles from start-bit drive) that lands in the cycle
  // between the last stop-bit sample and the cfg_data load:
  // 2 sync flops + 1 start detect + half bit + 9 bits to the stop-bit middle.
  localparam int CLR_AT = 3 + BD / 2 + 9 * BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_rdy = 1'b0;
  logic        strt_tx = 1'b0;
  logic [15:0] tx_data = '0;
  logic        TX, frm_rdy, tx_busy, frm_ovr;
  logic [23:0] cfg_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ovr_cycles = 0;
  bit          tx_mon_en = 1'b1;
  logic [23:0] rx_q[$];
  logic [15:0] tx_q[$];
  logic [23:0] prev_data = '0;
  logic        prev_rdy = 1'b0;
  logic [19:0] wave;

  always #5 clk = ~clk;

  cfg_uart #(.BAUD_DIV(BD), .FRAME_TO(20)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cfg_data (cfg_data),
    .frm_rdy  (frm_rdy),
    .clr_rdy  (clr_rdy),
    .strt_tx  (strt_tx),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .frm_ovr  (frm_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int c = 0; c < 10 * BD; c++) begin
      RX      = f[c / BD];
      clr_rdy = (c == clr_at);
      @(negedge clk);
    end
    clr_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] v);
    rx_q.push_back(v);
    send_byte(v[23:16], 1'b1, -1);
    send_byte(v[15:8],  1'b1, -1);
    send_byte(v[7:0],   1'b1, -1);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // RX scoreboard: a frame load shows as frm_rdy rising or cfg_data changing
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_data = '0;
      prev_rdy  = 1'b0;
    end else begin
      if (frm_ovr) ovr_cycles++;
      if ((frm_rdy && !prev_rdy) || (cfg_data != prev_data)) begin
        check("rx_sb_nonempty", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) check("rx_frame", cfg_data, rx_q.pop_front());
      end
      prev_data = cfg_data;
      prev_rdy  = frm_rdy;
    end
  end

  // TX scoreboard: deserialise both bytes from the TX line
  task automatic get_tx_byte(output logic [7:0] b);
    repeat (BD / 2 - 1) @(negedge clk);
    check("tx_start_bit", TX, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = TX;
    end
    repeat (BD) @(negedge clk);
    check("tx_stop_bit", TX, 1);
  endtask

  initial begin : tx_mon
    logic       prev;
    logic [7:0] hi, lo;
    bit         got2;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && rst_n && prev && !TX) begin
        get_tx_byte(hi);
        got2 = 1'b0;
        for (int i = 0; i < 2 * BD && !got2; i++) begin
          @(negedge clk);
          if (!TX) got2 = 1'b1;
        end
        check("tx_second_byte", got2, 1);
        if (got2) begin
          get_tx_byte(lo);
          check("tx_sb_nonempty", tx_q.size() != 0, 1);
          if (tx_q.size() != 0) check("tx_word", {hi, lo}, tx_q.pop_front());
        end
      end
      prev = TX;
    end
  end

  initial begin
    @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_cfg", cfg_data, 0);
    check("rst_rdy", frm_rdy, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_ovr", frm_ovr, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // basic frame and clr_rdy handshake
    send_frame(24'h0C1234);
    check("t1_rdy", frm_rdy, 1);
    check("t1_data", cfg_data, 24'h0C1234);
    pulse_clr();
    check("t1_clr", frm_rdy, 0);
    check("t1_keep", cfg_data, 24'h0C1234);

    // transmit waveform, busy window, ignored strt_tx at 40 and at busy fall
    wave = {1'b1, 8'h5A, 1'b0, 1'b1, 8'h0A, 1'b0};
    tx_data = 16'h0A5A;
    strt_tx = 1'b1;
    tx_q.push_back(16'h0A5A);
    for (int k = 1; k <= 162; k++) begin
      @(negedge clk);
      strt_tx = 1'b0;
      if (k <= 160) begin
        check("tx_wave", TX, wave[(k - 1) / BD]);
        check("tx_busy", tx_busy, 1);
      end else begin
        check("tx_idle", TX, 1);
        check("tx_busy_end", tx_busy, 0);
      end
      if (k == 40 || k == 160) begin
        tx_data = 16'hFFFF;
        strt_tx = 1'b1;
      end
    end
    strt_tx = 1'b0;
    repeat (4) @(negedge clk);

    // stale partial frame dropped after timeout
    send_byte(8'hDE, 1'b1, -1);
    send_byte(8'hAD, 1'b1, -1);
    repeat (20 * BD + 1) @(negedge clk);
    send_frame(24'hAABBCC);
    check("t3_rdy", frm_rdy, 1);
    pulse_clr();

    // framing error inside a frame
    send_byte(8'h55, 1'b1, -1);
    send_byte(8'h66, 1'b0, -1);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
    check("t4_no_rdy", frm_rdy, 0);
    send_frame(24'h010203);
    check("t4_rdy", frm_rdy, 1);
    pulse_clr();

    // short low glitch is not a byte
    RX = 1'b0;
    repeat (2) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    send_frame(24'h5AC37E);
    pulse_clr();

    // overrun, then clr_rdy coincident with completion
    send_frame(24'h102030);
    @(negedge clk);
    check("t6_no_ovr", ovr_cycles, 0);
    send_frame(24'h405060);
    @(negedge clk);
    check("t6_ovr_once", ovr_cycles, 1);
    check("t6_rdy_held", frm_rdy, 1);
    rx_q.push_back(24'h708090);
    send_byte(8'h70, 1'b1, -1);
    send_byte(8'h80, 1'b1, -1);
    send_byte(8'h90, 1'b1, CLR_AT);
    check("t6_set_wins", frm_rdy, 1);
    check("t6_data", cfg_data, 24'h708090);
    repeat (3) @(negedge clk);
    check("t6_no_ovr2", ovr_cycles, 1);
    check("rx_sb_drain", rx_q.size(), 0);
    check("tx_sb_drain", tx_q.size(), 0);

    // reset mid-transmit
    tx_mon_en = 1'b0;
    tx_data = 16'h1234;
    strt_tx = 1'b1;
    @(negedge clk);
    strt_tx = 1'b0;
    repeat (30) @(negedge clk);
    check("t7_busy_pre", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t7_tx", TX, 1);
    check("t7_busy", tx_busy, 0);
    check("t7_rdy", frm_rdy, 0);
    check("t7_cfg", cfg_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_uart.md
Name: cfg_uart

Overview:
- Serial command endpoint that faces the PID control FSM's command interface.
- Receives 3-byte configuration frames on a UART RX line and presents them as cfg_data with a frm_rdy/clr_rdy handshake.
- On strt_tx, serializes a 16-bit response (echo, ACK/NACK, EEPROM read data) as 2 bytes on TX.
- Sits between the chip UART pins and the control block.

Parameters:
BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range 4..65535
FRAME_TO, 20, idle bit-times after which a partial frame is discarded

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  UART serial in, idle high, asynchronous to clk
TX  output  1  UART serial out, idle high
cfg_data  output  24  last complete frame, byte0 in [23:16], byte1 in [15:8], byte2 in [7:0]
frm_rdy  output  1  high while an unconsumed frame is held in cfg_data
clr_rdy  input  1  one-cycle pulse from control; consumes frame
strt_tx  input  1  one-cycle pulse; latch tx_data and start transmit
tx_data  input  16  response word, sent MSB byte first
tx_busy  output  1  high from cycle after accepted strt_tx until end of last stop bit
frm_ovr  output  1  one-cycle pulse when a frame completes while frm_rdy already high

Behaviour:
- Reset (async, rst_n low) values: TX=1, cfg_data=0, frm_rdy=0, tx_busy=0, frm_ovr=0. Both FSMs go to IDLE, byte counter=0, synchronizer flops=1.
- Deasserting reset mid-byte or mid-frame restarts cleanly from IDLE.
- RX path:
  - RX passes through a 2-flop synchronizer; all decisions use the synced value.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synced RX=0; load baud counter with BAUD_DIV/2.
  - START: at count expiry, if RX=0 -> DATA (counter=BAUD_DIV); else glitch -> IDLE, no byte.
  - DATA: sample every BAUD_DIV cycles, 8 bits, LSB first into shift register -> STOP.
  - STOP: sample after BAUD_DIV.
    - RX=1: byte valid.
    - RX=0: framing error; byte discarded, frame byte counter cleared, FSM goes to IDLE, then waits for RX=1 before re-arming.
- Frame assembly:
  - Valid bytes fill a 3-byte buffer; counter 0..2.
  - On the third valid byte, the next cycle loads cfg_data, sets frm_rdy=1, and clears the counter.
  - Only complete frames ever update cfg_data; cfg_data is stable while frm_rdy=1 unless an overrun occurs.
  - Overrun: frame completes while frm_rdy=1 -> cfg_data overwritten, frm_rdy stays 1, frm_ovr pulses 1 cycle.
  - clr_rdy clears frm_rdy next cycle; cfg_data retained.
  - clr_rdy in the same cycle as frame completion: set wins, frm_rdy=1 with new data, no frm_ovr.
  - Frame timeout: counter nonzero and RX FSM in IDLE for FRAME_TO*BAUD_DIV consecutive cycles -> counter cleared, partial bytes dropped.
- TX path:
  - TX FSM states: IDLE, START, DATA, STOP.
  - strt_tx in IDLE latches tx_data; tx_busy=1 next cycle.
  - Sends byte tx_data[15:8] then tx_data[7:0]. Each byte is start(0), 8 data LSB first, stop(1); every bit lasts exactly BAUD_DIV cycles.
  - TX goes low the cycle after strt_tx.
  - Two bytes back-to-back, no idle gap; 20*BAUD_DIV cycles total.
  - tx_busy drops at the end of the second stop bit.
  - strt_tx while tx_busy=1 is ignored (no relatch, no queue).
  - strt_tx in the same cycle tx_busy falls is ignored; it is accepted only when tx_busy=0.
- RX and TX are fully independent and may operate simultaneously.

Test Plan:
- BAUD_DIV=8, send bytes 0x0C,0x12,0x34 on RX -> after final stop sample, cfg_data=0x0C1234, frm_rdy=1; pulse clr_rdy -> frm_rdy=0 next cycle, cfg_data unchanged.
- strt_tx with tx_data=0x0A5A -> TX waveform 0,0101_0000,1,0,0101_1010,1 (bit order LSB first per byte), each bit 8 cycles; tx_busy high 160 cycles; second strt_tx at cycle 40 ignored.
- Send 2 bytes, idle 20*8+1 cycles, then 0xAA,0xBB,0xCC -> cfg_data=0xAABBCC (stale partial dropped).
- Byte with stop bit=0 inside frame -> no frm_rdy; next 3 good bytes 0x01,0x02,0x03 -> cfg_data=0x010203.
- Two frames without clr_rdy -> frm_ovr one-cycle pulse, cfg_data=second frame; clr_rdy coincident with third frame completion -> frm_rdy remains 1.
- 2-cycle RX low glitch -> no byte received; assert rst_n low mid-transmit -> TX=1, tx_busy=0 immediately.
